// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and SRAM port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int LEN = 32
);
  logic           if_req;
  logic [LEN-1:0] if_addr;
  logic [LEN-1:0] if_rdata;
  logic           if_ready;
  logic           mem_r_en;
  logic           mem_w_en;
  logic [LEN-1:0] mem_addr;
  logic [LEN-1:0] mem_wdata;
  logic [LEN-1:0] mem_rdata;
  logic           mem_ready;
  logic           sram_en;
  logic           sram_we;
  logic [LEN-1:0] sram_addr;
  logic [LEN-1:0] sram_wdata;
  logic [LEN-1:0] sram_rdata;
  logic           freeze;
  logic           if_stall;

  // Requester plus SRAM side.
  modport master (
    output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we,
           sram_addr, sram_wdata, freeze, if_stall
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we,
           sram_addr, sram_wdata, freeze, if_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port SRAM arbiter between instruction fetch and data access
// Optional ARB_STATS_EN adds a saturating 16-bit conflict_cnt output.
module mem_arbiter #(
  parameter int LEN       = 32,
  parameter int SRAM_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     cnt;
  logic           owner_data;
  logic           wr;
  logic [LEN-1:0] addr_q;
  logic [LEN-1:0] wdata_q;
  logic [LEN-1:0] if_rdata_q;
  logic [LEN-1:0] mem_rdata_q;
  logic           data_req;
  logic           grant;

  assign data_req = bus.mem_r_en | bus.mem_w_en;
  assign grant    = (state == IDLE) && (data_req || bus.if_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data requests take priority over fetch whenever both are pending in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 4'd0;
      owner_data  <= 1'b0;
      wr          <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else if (grant) begin
      cnt        <= 4'(SRAM_WAIT - 1);
      owner_data <= data_req;
      wr         <= data_req & bus.mem_w_en;
      addr_q     <= data_req ? bus.mem_addr : bus.if_addr;
      wdata_q    <= bus.mem_wdata;
    end else if (state == BUSY) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else if (!wr) begin
        if (owner_data) begin
          mem_rdata_q <= bus.sram_rdata;
        end else begin
          if_rdata_q <= bus.sram_rdata;
        end
      end
    end
  end

  assign bus.sram_en    = (state == BUSY);
  assign bus.sram_we    = (state == BUSY) && owner_data && wr;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.if_ready   = (state == DONE) && !owner_data;
  assign bus.mem_ready  = (state == DONE) && owner_data;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.freeze     = data_req & ~bus.mem_ready;
  assign bus.if_stall   = bus.if_req & ~bus.if_ready;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if ((state == IDLE) && data_req && bus.if_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
